warp_scheduler: RTL

- Round-robin multi-warp scheduler for the next-generation GPU core; successor to the core's single-fetch warp sequencing.
- Tracks per-warp PC and state for NUM_WARPS warps and derives per-warp active-thread masks from thread_count.
- Drives the fetcher handshake and the execute handshake to the shared decode/ALU/LSU datapath.
- Hides memory latency: a warp waiting on memory is parked while other warps issue.

---
 rtl/warp_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks a ready warp, runs the fetch and execute handshakes,
// and parks warps that wait on memory so that other warps can issue.
module warp_scheduler #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int PC_BITS          = 8,
    parameter int WARP_ID_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  thread_count,
    output logic                        fetch_valid,
    output logic [PC_BITS-1:0]          fetch_pc,
    input  logic                        fetch_ready,
    output logic                        exec_valid,
    output logic [WARP_ID_BITS-1:0]     issue_warp_id,
    output logic [THREADS_PER_WARP-1:0] issue_mask,
    input  logic                        exec_done,
    input  logic [PC_BITS-1:0]          exec_next_pc,
    input  logic                        exec_is_mem,
    input  logic                        exec_is_ret,
    input  logic                        mem_done,
    input  logic [WARP_ID_BITS-1:0]     mem_done_warp_id,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_FETCH,
        S_EXEC,
        S_FINISH
    } sched_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_READY,
        W_WAIT_MEM,
        W_DONE
    } warp_state_t;

    sched_state_t              state_reg;
    warp_state_t               warp_state_reg [NUM_WARPS];
    logic [PC_BITS-1:0]        warp_pc_reg    [NUM_WARPS];
    logic [7:0]                thread_count_reg;
    logic [WARP_ID_BITS-1:0]   rr_ptr_reg;

    // run_mask follows the latched count; launch_mask is evaluated on the
    // incoming count so warp eligibility is known at the accepting edge.
    logic [THREADS_PER_WARP-1:0] run_mask    [NUM_WARPS];
    logic [THREADS_PER_WARP-1:0] launch_mask [NUM_WARPS];

    genvar gi, gt;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            for (gt = 0; gt < THREADS_PER_WARP; gt++) begin : g_thread
                localparam logic [15:0] TID = 16'(gi * THREADS_PER_WARP + gt);
                assign run_mask[gi][gt]    = TID < {8'd0, thread_count_reg};
                assign launch_mask[gi][gt] = TID < {8'd0, thread_count};
            end
        end
    endgenerate

    logic                    pick_found;
    logic [WARP_ID_BITS-1:0] pick_id;
    logic                    any_wait;
    logic [WARP_ID_BITS-1:0] rr_next;

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        any_wait   = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_WARPS;
            if (!pick_found && warp_state_reg[idx] == W_READY) begin
                pick_found = 1'b1;
                pick_id    = WARP_ID_BITS'(idx);
            end
            if (warp_state_reg[i] == W_WAIT_MEM) begin
                any_wait = 1'b1;
            end
        end
    end

    assign rr_next = (int'(issue_warp_id) == NUM_WARPS - 1) ? '0 : issue_warp_id + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            thread_count_reg <= '0;
            rr_ptr_reg       <= '0;
            fetch_valid      <= 1'b0;
            fetch_pc         <= '0;
            exec_valid       <= 1'b0;
            issue_warp_id    <= '0;
            issue_mask       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_state_reg[w] <= W_IDLE;
                warp_pc_reg[w]    <= '0;
            end
        end else begin
            // Memory completions land in any scheduler state; the exec update below
            // targets a warp that is W_READY, so the two never disagree.
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (mem_done && mem_done_warp_id == WARP_ID_BITS'(w) &&
                    warp_state_reg[w] == W_WAIT_MEM) begin
                    warp_state_reg[w] <= W_READY;
                end
            end

            case (state_reg)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        thread_count_reg <= thread_count;
                        for (int w = 0; w < NUM_WARPS; w++) begin
                            warp_state_reg[w] <= (|launch_mask[w]) ? W_READY : W_IDLE;
                            warp_pc_reg[w]    <= '0;
                        end
                        rr_ptr_reg <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        state_reg  <= S_PICK;
                    end
                end

                S_PICK: begin
                    if (pick_found) begin
                        issue_warp_id <= pick_id;
                        issue_mask    <= run_mask[pick_id];
                        fetch_pc      <= warp_pc_reg[pick_id];
                        fetch_valid   <= 1'b1;
                        state_reg     <= S_FETCH;
                    end else if (!any_wait) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_FINISH;
                    end
                end

                S_FETCH: begin
                    if (fetch_ready) begin
                        fetch_valid <= 1'b0;
                        exec_valid  <= 1'b1;
                        state_reg   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (exec_done) begin
                        exec_valid                 <= 1'b0;
                        warp_pc_reg[issue_warp_id] <= exec_next_pc;
                        if (exec_is_ret) begin
                            warp_state_reg[issue_warp_id] <= W_DONE;
                        end else if (exec_is_mem) begin
                            warp_state_reg[issue_warp_id] <= W_WAIT_MEM;
                        end else begin
                            warp_state_reg[issue_warp_id] <= W_READY;
                        end
                        rr_ptr_reg <= rr_next;
                        state_reg  <= S_PICK;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
